// File: rtl/rvvi_tx_arbiter_pkg.sv
// rvvi_tx_arbiter_pkg: shared RVVI transmit-arbiter state encoding and helpers.
//   Exports: rvvi_tx_state_t, RVVI_TX_IDLE/PASS/DRAIN, sat_inc16().
package rvvi_tx_arbiter_pkg;

    typedef logic [1:0] rvvi_tx_state_t;

    localparam rvvi_tx_state_t RVVI_TX_IDLE  = 2'd0;
    localparam rvvi_tx_state_t RVVI_TX_PASS  = 2'd1;
    localparam rvvi_tx_state_t RVVI_TX_DRAIN = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rvvi_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, search starts at last+1 mod N.
//   req  : request vector
//   last : index of the previous winner
//   gnt  : one-hot winner (zero when no request)
//   idx  : encoded winner index
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int   c;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        c     = 0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(last) + i) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/rvvi_tx_arbiter.sv
// rvvi_tx_arbiter: frame-granular round-robin share of the MAC AXI-stream TX port.
//   m_axi_aclk/m_axi_aresetn : clock, async active-low reset
//   TxEnable                 : gates new grants (sampled in IDLE only)
//   SAxisT*                  : NUM_REQ requester streams (32-bit lanes)
//   MAxisT*                  : stream to the MAC, zero-latency pass-through
//   Grant                    : one-hot owner, zero in IDLE
//   FrameTruncated/TruncCount: watchdog pulse and saturating count
module rvvi_tx_arbiter
    import rvvi_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_FRAME_BEATS = 400
) (
    input  logic                   m_axi_aclk,
    input  logic                   m_axi_aresetn,
    input  logic                   TxEnable,
    input  logic [NUM_REQ*32-1:0]  SAxisTdata,
    input  logic [NUM_REQ*4-1:0]   SAxisTkeep,
    input  logic [NUM_REQ-1:0]     SAxisTvalid,
    input  logic [NUM_REQ-1:0]     SAxisTlast,
    output logic [NUM_REQ-1:0]     SAxisTready,
    output logic [31:0]            MAxisTdata,
    output logic [3:0]             MAxisTkeep,
    output logic                   MAxisTvalid,
    output logic                   MAxisTlast,
    input  logic                   MAxisTready,
    output logic [NUM_REQ-1:0]     Grant,
    output logic                   FrameTruncated,
    output logic [15:0]            TruncCount
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_FRAME_BEATS);
    localparam logic [BW-1:0] LIMIT = BW'(MAX_FRAME_BEATS - 1);

    rvvi_tx_state_t     state;
    logic [NUM_REQ-1:0] grant, win;
    logic [IW-1:0]      last_grant, win_idx;
    logic [BW-1:0]      beat_count;
    logic [15:0]        trunc_count;
    logic               in_pass, in_drain, own_valid, own_last, at_limit, accept;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (SAxisTvalid),
        .last(last_grant),
        .gnt (win),
        .idx (win_idx)
    );

    // last_grant doubles as the owner index while a frame is in flight
    assign in_pass        = state == RVVI_TX_PASS;
    assign in_drain       = state == RVVI_TX_DRAIN;
    assign own_valid      = SAxisTvalid[last_grant];
    assign own_last       = SAxisTlast[last_grant];
    assign at_limit       = beat_count == LIMIT;
    assign MAxisTdata     = in_pass ? SAxisTdata[32*last_grant +: 32] : '0;
    assign MAxisTkeep     = in_pass ? SAxisTkeep[4*last_grant +: 4] : '0;
    assign MAxisTvalid    = in_pass & own_valid;
    assign MAxisTlast     = in_pass & (own_last | at_limit);
    assign accept         = MAxisTvalid & MAxisTready;
    assign FrameTruncated = accept & at_limit & ~own_last;
    assign SAxisTready    = in_drain ? grant : (in_pass && MAxisTready) ? grant : '0;
    assign Grant          = grant;
    assign TruncCount     = trunc_count;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state       <= RVVI_TX_IDLE;
            grant       <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
            beat_count  <= '0;
            trunc_count <= '0;
        end else if (state == RVVI_TX_IDLE) begin
            if (TxEnable && |SAxisTvalid) begin
                grant      <= win;
                last_grant <= win_idx;
                beat_count <= '0;
                state      <= RVVI_TX_PASS;
            end
        end else if (in_pass) begin
            if (accept) begin
                if (own_last) begin
                    state <= RVVI_TX_IDLE;
                    grant <= '0;
                end else if (at_limit) begin
                    state       <= RVVI_TX_DRAIN;
                    trunc_count <= sat_inc16(trunc_count);
                end else begin
                    beat_count <= beat_count + 1'b1;
                end
            end
        end else if (!in_drain || (own_valid && own_last)) begin
            // drain ends on the owner's tlast; an unused encoding recovers to IDLE
            state <= RVVI_TX_IDLE;
            grant <= '0;
        end
    end

endmodule

// File: doc/rvvi_tx_arbiter.md
# rvvi_tx_arbiter

Frame-granular arbiter that shares the single 32-bit AXI-stream transmit port of the Ethernet MAC FIFO between several frame sources. Typical sources are the RVVI packetizer, the slow-down and host-stall frame generator, and future status or heartbeat frames. It sits between those sources and the MAC `tx_axis_*` inputs in the hardware tracer top level. It never interleaves beats of different frames, and it protects the MAC from runaway frames with a beat-count watchdog.

## Interface
- `NUM_REQ`, default 2: number of requesters. Range 2–8. Index 0 is the RVVI packetizer.
- `MAX_FRAME_BEATS`, default 400: maximum 32-bit beats per frame before forced truncation. Range 2–65535.
- `m_axi_aclk`, in, 1: the single clock.
- `m_axi_aresetn`, in, 1: reset. Asynchronous and active-low.
- `TxEnable`, in, 1: when low, no new grant is issued. The frame in flight still completes.
- `SAxisTdata`, in, NUM_REQ*32: requester data. Requester i uses bits [32i+31:32i].
- `SAxisTkeep`, in, NUM_REQ*4: requester byte strobes.
- `SAxisTvalid`, in, NUM_REQ: per-requester valid.
- `SAxisTlast`, in, NUM_REQ: per-requester end of frame.
- `SAxisTready`, out, NUM_REQ: per-requester ready.
- `MAxisTdata`, out, 32: data to the MAC.
- `MAxisTkeep`, out, 4: byte strobes to the MAC.
- `MAxisTvalid`, out, 1: valid to the MAC.
- `MAxisTlast`, out, 1: end of frame to the MAC.
- `MAxisTready`, in, 1: ready from the MAC.
- `Grant`, out, NUM_REQ: one-hot current owner. All zero when in IDLE.
- `FrameTruncated`, out, 1: one-cycle pulse on the beat where the watchdog forces tlast.
- `TruncCount`, out, 16: number of truncated frames. Saturates at 16'hFFFF.

## Operation
- The FSM has three states: IDLE, PASS and DRAIN.
- IDLE:
  - All `SAxisTready` = 0 and `MAxisTvalid` = 0.
  - If `TxEnable` = 1 and any `SAxisTvalid` = 1, pick the winner round-robin. The search starts at `LastGrant`+1 modulo NUM_REQ.
  - On the next edge, register `Grant` and `LastGrant` ← winner, clear `BeatCount`, and go to PASS.
- PASS:
  - Combinational pass-through from the owner: `MAxisT{data,keep,valid}` = owner's signals, and owner `SAxisTready` = `MAxisTready`.
  - Non-owner ready is 0.
  - A beat is accepted when `MAxisTvalid` & `MAxisTready`. Each accepted beat increments `BeatCount`.
  - `MAxisTlast` = owner tlast, OR (`BeatCount` == MAX_FRAME_BEATS-1).
  - Accepted beat with owner tlast = 1: go to IDLE and clear `Grant`.
  - Accepted beat with `BeatCount` == MAX_FRAME_BEATS-1 and owner tlast = 0:
    - force `MAxisTlast` = 1 and pulse `FrameTruncated`;
    - increment `TruncCount` (saturating);
    - go to DRAIN.
  - If owner tlast = 1 on the limit beat, this is a normal end. There is no truncation pulse.
- DRAIN:
  - Owner `SAxisTready` = 1 and `MAxisTvalid` = 0. Remaining owner beats are discarded.
  - When an owner beat with tlast = 1 is accepted, go to IDLE and clear `Grant`.
- `TxEnable` is sampled only in IDLE. Deasserting it in PASS or DRAIN has no effect on the frame in flight.
- A requester deasserting valid mid-frame while it owns the port is a legal bubble. Ownership is kept and no watchdog time is charged; only accepted beats are counted.
- Reset values:
  - state = IDLE;
  - `Grant` = 0;
  - `LastGrant` = NUM_REQ-1, so requester 0 wins first;
  - `BeatCount` = 0 and `TruncCount` = 0;
  - every output = 0.
- Reset mid-frame returns to IDLE immediately. The MAC sees a frame without tlast; the MAC FIFO's bad-frame handling covers this.

## Timing
- Arbitration latency: one cycle. Valid seen in IDLE at edge N gives `Grant` valid after edge N, and the first beat can transfer in cycle N+1.
- Data path latency: zero. Ready and valid are combinational through the arbiter and there is no register stage.
- Back-to-back frames: a one-cycle IDLE gap after every tlast.
- `BeatCount` width is $clog2(MAX_FRAME_BEATS). `TruncCount` increments at most once per frame.

## Structure
- The state enum (IDLE, PASS, DRAIN) goes in the shared `cvw` package, as an RVVI section typedef.
- Sub-module `rr_arbiter #(N)`:
  - inputs: request vector and last-grant index;
  - outputs: one-hot winner and its encoded index;
  - purely combinational, so it can be reused elsewhere in the RVVI path.

## Test plan
- Single requester, 3-beat frame, `MAxisTready` = 1: `Grant` = 01 one cycle after valid; 3 beats appear unchanged; tlast on beat 3; `Grant` = 00 next cycle.
- Both requesters valid continuously with 2-beat frames: grants alternate 01, 10, 01, 10, with one idle cycle between frames and no interleaved beats.
- `MAxisTready` toggling 1,0,1,0 during a 4-beat frame: all 4 beats are delivered in order and the owner sees ready follow `MAxisTready`.
- With `MAX_FRAME_BEATS` = 4, requester sends 6 beats:
  - beat 4 goes out with tlast = 1, `FrameTruncated` pulses and `TruncCount` = 1;
  - beats 5–6 are accepted and dropped (`MAxisTvalid` = 0), then IDLE.
- With `MAX_FRAME_BEATS` = 4, requester sends exactly 4 beats with tlast on beat 4: no pulse and `TruncCount` stays 0.
- `TxEnable` dropped mid-frame: the frame completes and no new grant is issued while a requester is valid. Raising `TxEnable` gives a grant one cycle later.
